// File: rtl/pipeline_hazard_unit.sv
// Hazard control beside the ID-stage decoder: load-use stalls, branch/jump flushes
// and multi-cycle EX occupancy for SPECIAL2 multiplies.
module pipeline_hazard_unit #(
    parameter int MULT_LATENCY = 4,
    parameter int STALL_CNT_W  = 16
) (
    input  logic                   Clk,
    input  logic                   Rst,
    input  logic [4:0]             ID_Rs,
    input  logic [4:0]             ID_Rt,
    input  logic                   ID_UsesRt,
    input  logic                   ID_IsMult,
    input  logic                   ID_Jump,
    input  logic                   IDEX_MemRead,
    input  logic [4:0]             IDEX_Rt,
    input  logic                   EX_BranchTaken,
    output logic                   PCWrite,
    output logic                   IFID_Write,
    output logic                   IFID_Flush,
    output logic                   IDEX_Bubble,
    output logic                   EXMEM_Bubble,
    output logic [2:0]             StageWriteEnable,
    output logic [STALL_CNT_W-1:0] StallCount,
    output logic [1:0]             DbgState
);

    typedef enum logic [1:0] {
        RUN        = 2'd0,
        LOAD_STALL = 2'd1,
        MULT_BUSY  = 2'd2
    } state_t;

    localparam bit         MULT_MULTI = (MULT_LATENCY > 1);
    localparam logic [3:0] MULT_INIT  = MULT_MULTI ? 4'(MULT_LATENCY - 2) : 4'd0;

    state_t                 state_q, state_d;
    logic [3:0]             mult_cnt_q, mult_cnt_d;
    logic [STALL_CNT_W-1:0] stall_cnt_q;
    logic                   load_use;

    // Handshake-free control: every output is a pure function of state and ID/EX inputs.
    assign load_use = IDEX_MemRead && (IDEX_Rt != 5'd0) &&
                      ((IDEX_Rt == ID_Rs) || (ID_UsesRt && (IDEX_Rt == ID_Rt)));

    always_comb begin
        PCWrite          = 1'b1;
        IFID_Write       = 1'b1;
        IFID_Flush       = 1'b0;
        IDEX_Bubble      = 1'b0;
        EXMEM_Bubble     = 1'b0;
        StageWriteEnable = 3'b111;
        state_d          = state_q;
        mult_cnt_d       = mult_cnt_q;

        if (Rst) begin
            PCWrite          = 1'b0;
            IFID_Write       = 1'b0;
            IFID_Flush       = 1'b1;
            IDEX_Bubble      = 1'b1;
            EXMEM_Bubble     = 1'b1;
            StageWriteEnable = 3'b000;
            state_d          = RUN;
            mult_cnt_d       = 4'd0;
        end else begin
            case (state_q)
                RUN, LOAD_STALL: begin
                    state_d = RUN;
                    if (EX_BranchTaken) begin
                        IFID_Flush  = 1'b1;
                        IDEX_Bubble = 1'b1;
                    end else if (load_use && (state_q == RUN)) begin
                        // Jump in ID is deferred until the stalled instruction re-issues.
                        PCWrite     = 1'b0;
                        IFID_Write  = 1'b0;
                        IDEX_Bubble = 1'b1;
                        state_d     = LOAD_STALL;
                    end else if (ID_IsMult && MULT_MULTI) begin
                        state_d    = MULT_BUSY;
                        mult_cnt_d = MULT_INIT;
                    end else if (ID_Jump) begin
                        IFID_Flush = 1'b1;
                    end
                end
                MULT_BUSY: begin
                    PCWrite          = 1'b0;
                    IFID_Write       = 1'b0;
                    StageWriteEnable = 3'b110;
                    EXMEM_Bubble     = 1'b1;
                    if (mult_cnt_q == 4'd0) begin
                        state_d = RUN;
                    end else begin
                        mult_cnt_d = mult_cnt_q - 4'd1;
                    end
                end
                default: state_d = RUN;
            endcase
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q     <= RUN;
            mult_cnt_q  <= 4'd0;
            stall_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            mult_cnt_q <= mult_cnt_d;
            if (!PCWrite && (stall_cnt_q != {STALL_CNT_W{1'b1}})) begin
                stall_cnt_q <= stall_cnt_q + 1'b1;
            end
        end
    end

    assign StallCount = stall_cnt_q;
    assign DbgState   = state_q;

endmodule

// File: tb/tb_pipeline_hazard_unit.sv
// Directed bench for pipeline_hazard_unit: reset, load-use, branch/jump flush,
// multiply occupancy, reset abort and stall-counter saturation.
module tb_pipeline_hazard_unit;

    localparam int CW = 6;

    localparam logic [7:0] O_RST  = 8'b0011_1000;
    localparam logic [7:0] O_RUN  = 8'b1100_0111;
    localparam logic [7:0] O_LOAD = 8'b0001_0111;
    localparam logic [7:0] O_BR   = 8'b1111_0111;
    localparam logic [7:0] O_JMP  = 8'b1110_0111;
    localparam logic [7:0] O_BUSY = 8'b0000_1110;

    localparam logic [1:0] S_RUN  = 2'd0;
    localparam logic [1:0] S_LOAD = 2'd1;
    localparam logic [1:0] S_BUSY = 2'd2;

    logic          Clk = 1'b0;
    logic          Rst;
    logic [4:0]    ID_Rs, ID_Rt, IDEX_Rt;
    logic          ID_UsesRt, ID_IsMult, ID_Jump, IDEX_MemRead, EX_BranchTaken;
    logic          PCWrite, IFID_Write, IFID_Flush, IDEX_Bubble, EXMEM_Bubble;
    logic [2:0]    StageWriteEnable;
    logic [CW-1:0] StallCount;
    logic [1:0]    DbgState;
    logic          PCWrite1, IFID_Write1, IFID_Flush1, IDEX_Bubble1, EXMEM_Bubble1;
    logic [2:0]    StageWriteEnable1;
    logic [CW-1:0] StallCount1;
    logic [1:0]    DbgState1;

    int vec_cnt  = 0;
    int miss_cnt = 0;

    always #5 Clk = ~Clk;

    pipeline_hazard_unit #(.MULT_LATENCY(4), .STALL_CNT_W(CW)) dut (
        .Clk(Clk), .Rst(Rst), .ID_Rs(ID_Rs), .ID_Rt(ID_Rt), .ID_UsesRt(ID_UsesRt),
        .ID_IsMult(ID_IsMult), .ID_Jump(ID_Jump), .IDEX_MemRead(IDEX_MemRead),
        .IDEX_Rt(IDEX_Rt), .EX_BranchTaken(EX_BranchTaken), .PCWrite(PCWrite),
        .IFID_Write(IFID_Write), .IFID_Flush(IFID_Flush), .IDEX_Bubble(IDEX_Bubble),
        .EXMEM_Bubble(EXMEM_Bubble), .StageWriteEnable(StageWriteEnable),
        .StallCount(StallCount), .DbgState(DbgState)
    );

    pipeline_hazard_unit #(.MULT_LATENCY(1), .STALL_CNT_W(CW)) dut1 (
        .Clk(Clk), .Rst(Rst), .ID_Rs(ID_Rs), .ID_Rt(ID_Rt), .ID_UsesRt(ID_UsesRt),
        .ID_IsMult(ID_IsMult), .ID_Jump(ID_Jump), .IDEX_MemRead(IDEX_MemRead),
        .IDEX_Rt(IDEX_Rt), .EX_BranchTaken(EX_BranchTaken), .PCWrite(PCWrite1),
        .IFID_Write(IFID_Write1), .IFID_Flush(IFID_Flush1), .IDEX_Bubble(IDEX_Bubble1),
        .EXMEM_Bubble(EXMEM_Bubble1), .StageWriteEnable(StageWriteEnable1),
        .StallCount(StallCount1), .DbgState(DbgState1)
    );

    function automatic logic [7:0] outs();
        return {PCWrite, IFID_Write, IFID_Flush, IDEX_Bubble, EXMEM_Bubble, StageWriteEnable};
    endfunction

    function automatic logic [7:0] outs1();
        return {PCWrite1, IFID_Write1, IFID_Flush1, IDEX_Bubble1, EXMEM_Bubble1, StageWriteEnable1};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec_cnt++;
        assert (obs === exp) else begin
            miss_cnt++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic idle();
        ID_Rs = 5'd0; ID_Rt = 5'd0; ID_UsesRt = 1'b0; ID_IsMult = 1'b0; ID_Jump = 1'b0;
        IDEX_MemRead = 1'b0; IDEX_Rt = 5'd0; EX_BranchTaken = 1'b0;
    endtask

    initial begin
        Rst = 1'b1;
        idle();
        #1;
        chk("rst_outs_c0", 32'(outs()), 32'(O_RST));
        tick();
        chk("rst_outs_c1", 32'(outs()), 32'(O_RST));
        tick();
        Rst = 1'b0;
        #1;
        chk("post_rst_outs", 32'(outs()), 32'(O_RUN));
        chk("post_rst_cnt", 32'(StallCount), 32'd0);
        chk("post_rst_state", 32'(DbgState), 32'(S_RUN));

        // Load-use on rs
        IDEX_MemRead = 1'b1; IDEX_Rt = 5'd5; ID_Rs = 5'd5;
        #1;
        chk("lu_rs_outs", 32'(outs()), 32'(O_LOAD));
        tick();
        chk("lu_state", 32'(DbgState), 32'(S_LOAD));
        chk("lu_hold_outs", 32'(outs()), 32'(O_RUN));
        chk("lu_cnt", 32'(StallCount), 32'd1);
        tick();
        chk("lu_back_state", 32'(DbgState), 32'(S_RUN));

        // Load to r0 never stalls
        IDEX_Rt = 5'd0; ID_Rs = 5'd0;
        #1;
        chk("lu_r0_outs", 32'(outs()), 32'(O_RUN));
        tick();
        chk("lu_r0_cnt", 32'(StallCount), 32'd1);

        // rt match only counts when ID reads rt
        IDEX_Rt = 5'd7; ID_Rt = 5'd7; ID_Rs = 5'd3; ID_UsesRt = 1'b0;
        #1;
        chk("lu_rt_unused", 32'(outs()), 32'(O_RUN));
        ID_UsesRt = 1'b1;
        #1;
        chk("lu_rt_used", 32'(outs()), 32'(O_LOAD));
        tick();
        idle();
        #1;
        chk("lu_rt_cnt", 32'(StallCount), 32'd2);
        tick();

        // Branch beats load-use
        IDEX_MemRead = 1'b1; IDEX_Rt = 5'd5; ID_Rs = 5'd5; EX_BranchTaken = 1'b1;
        #1;
        chk("br_outs", 32'(outs()), 32'(O_BR));
        tick();
        idle();
        #1;
        chk("br_state", 32'(DbgState), 32'(S_RUN));
        chk("br_cnt", 32'(StallCount), 32'd2);

        // Multiply occupies EX for 4 cycles
        ID_IsMult = 1'b1;
        #1;
        chk("mul_issue_outs", 32'(outs()), 32'(O_RUN));
        tick();
        idle();
        #1;
        chk("mul_b1_state", 32'(DbgState), 32'(S_BUSY));
        chk("mul_b1_outs", 32'(outs()), 32'(O_BUSY));
        chk("lat1_no_busy_state", 32'(DbgState1), 32'(S_RUN));
        chk("lat1_no_busy_outs", 32'(outs1()), 32'(O_RUN));
        tick();
        EX_BranchTaken = 1'b1; ID_Jump = 1'b1;
        #1;
        chk("mul_b2_br_ignored", 32'(outs()), 32'(O_BUSY));
        tick();
        idle();
        #1;
        chk("mul_b3_outs", 32'(outs()), 32'(O_BUSY));
        tick();
        chk("mul_done_state", 32'(DbgState), 32'(S_RUN));
        chk("mul_done_outs", 32'(outs()), 32'(O_RUN));
        chk("mul_done_cnt", 32'(StallCount), 32'd5);

        // Jump behind a load-use is deferred one cycle
        ID_Jump = 1'b1; IDEX_MemRead = 1'b1; IDEX_Rt = 5'd5; ID_Rs = 5'd5;
        #1;
        chk("jmp_lu_outs", 32'(outs()), 32'(O_LOAD));
        tick();
        IDEX_MemRead = 1'b0;
        #1;
        chk("jmp_after_outs", 32'(outs()), 32'(O_JMP));
        chk("jmp_cnt", 32'(StallCount), 32'd6);
        tick();
        idle();

        // Reset aborts MULT_BUSY
        ID_IsMult = 1'b1;
        tick();
        idle();
        tick();
        chk("abort_pre_state", 32'(DbgState), 32'(S_BUSY));
        chk("abort_pre_cnt", 32'(StallCount), 32'd7);
        Rst = 1'b1;
        #1;
        chk("abort_rst_outs", 32'(outs()), 32'(O_RST));
        tick();
        Rst = 1'b0;
        #1;
        chk("abort_state", 32'(DbgState), 32'(S_RUN));
        chk("abort_outs", 32'(outs()), 32'(O_RUN));
        chk("abort_cnt", 32'(StallCount), 32'd0);

        // Back-to-back multiplies drive the counter to saturation
        ID_IsMult = 1'b1;
        for (int i = 0; i < 100; i++) tick();
        idle();
        #1;
        chk("sat_cnt", 32'(StallCount), 32'(6'h3f));
        for (int i = 0; i < 4; i++) tick();
        chk("sat_hold_cnt", 32'(StallCount), 32'(6'h3f));
        chk("sat_end_state", 32'(DbgState), 32'(S_RUN));

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
        $finish;
    end

endmodule

// File: doc/pipeline_hazard_unit.md
Name: pipeline_hazard_unit

Overview:
- Consumes the per-stage control signals produced by the ID-stage control decoder: MemRead, Jump, Branch outcome, and the multiply opcode class.
- Drives the pipeline-register enables, bubbles and flushes that those signals require.
- Handles load-use stalls, branch/jump flushes, and multi-cycle EX occupancy for SPECIAL2 multiplies.
- Sits beside the datapath controller in ID and owns PC, IF/ID, ID/EX, EX/MEM and MEM/WB write control.

Parameters:
- MULT_LATENCY, 4, total cycles a SPECIAL2 multiply occupies EX (legal range 1..16).
- STALL_CNT_W, 16, width of the stall-cycle counter.

Ports:
- Clk  input  1  system clock, all state updates on rising edge
- Rst  input  1  synchronous, active-high reset
- ID_Rs  input  5  rs field of instruction in ID
- ID_Rt  input  5  rt field of instruction in ID
- ID_UsesRt  input  1  ID instruction reads rt (R-type, branches, SW)
- ID_IsMult  input  1  ID opcode is 011100
- ID_Jump  input  1  Jump control from decoder (J, JAL, JR)
- IDEX_MemRead  input  1  load currently in EX
- IDEX_Rt  input  5  destination register of load in EX
- EX_BranchTaken  input  1  branch in EX resolved taken
- PCWrite  output  1  PC update enable
- IFID_Write  output  1  IF/ID register enable
- IFID_Flush  output  1  IF/ID loads NOP
- IDEX_Bubble  output  1  ID/EX loads NOP (all controls zero)
- EXMEM_Bubble  output  1  EX/MEM loads NOP
- StageWriteEnable  output  3  bit0 ID/EX, bit1 EX/MEM, bit2 MEM/WB enable
- StallCount  output  STALL_CNT_W  saturating count of cycles with PCWrite=0

Behaviour:
- Clk/Rst: single clock domain. Rst is synchronous and active-high.
- State is registered: RUN, LOAD_STALL, MULT_BUSY, plus a 4-bit MultCnt.
- Outputs are combinational from state and inputs.
- While Rst=1:
  - PCWrite=0, IFID_Write=0, IFID_Flush=1, IDEX_Bubble=1, EXMEM_Bubble=1, StageWriteEnable=3'b000.
  - On the edge: next state RUN, MultCnt=0, StallCount=0.
- Default outputs (RUN, no event): PCWrite=1, IFID_Write=1, flushes/bubbles 0, StageWriteEnable=3'b111.
- LoadUse = IDEX_MemRead & (IDEX_Rt!=0) & ((IDEX_Rt==ID_Rs) | (ID_UsesRt & IDEX_Rt==ID_Rt)).
- Priority in RUN/LOAD_STALL, first match wins:
  1. EX_BranchTaken: IFID_Flush=1, IDEX_Bubble=1, PCWrite=1. Next RUN. A coincident LoadUse or Jump is discarded because its instruction is flushed.
  2. LoadUse (RUN only): PCWrite=0, IFID_Write=0, IDEX_Bubble=1. Next LOAD_STALL. Any Jump in ID is deferred (IFID_Flush=0).
  3. ID_IsMult with MULT_LATENCY>1: default outputs (mult advances into EX). Next MULT_BUSY, MultCnt=MULT_LATENCY-2.
  4. ID_Jump: IFID_Flush=1, others default. Next RUN.
- LOAD_STALL: lasts exactly one cycle. LoadUse is ignored (ID/EX holds a bubble). Otherwise identical to RUN. Next RUN unless rule 3 fires.
- MULT_BUSY:
  - Outputs: PCWrite=0, IFID_Write=0, StageWriteEnable=3'b110 (ID/EX held), EXMEM_Bubble=1, IFID_Flush=0, IDEX_Bubble=0.
  - EX_BranchTaken, LoadUse and ID_Jump are ignored.
  - Decrement MultCnt each cycle. When MultCnt==0, next RUN.
  - Total stall cycles = MULT_LATENCY-1.
- MULT_LATENCY==1: MULT_BUSY is never entered.
- StallCount increments on each non-reset cycle with PCWrite=0 and saturates at all-ones.
- Rst asserted mid-stall or mid-MULT_BUSY aborts immediately; the following cycle is RUN.

Test Plan:
- Rst high 2 cycles, then low, idle inputs -> during reset IFID_Flush=1, StageWriteEnable=000; after, PCWrite=1, StageWriteEnable=111, StallCount=0.
- IDEX_MemRead=1, IDEX_Rt=5, ID_Rs=5 -> one cycle PCWrite=0, IFID_Write=0, IDEX_Bubble=1; next cycle normal; StallCount=1. Repeat with IDEX_Rt=0 -> no stall.
- Same load-use plus EX_BranchTaken=1 -> IFID_Flush=1, IDEX_Bubble=1, PCWrite=1, no stall, StallCount unchanged.
- ID_IsMult=1 for one cycle, MULT_LATENCY=4 -> next 3 cycles PCWrite=0, StageWriteEnable=110, EXMEM_Bubble=1; then RUN; StallCount=3. EX_BranchTaken pulsed mid-busy is ignored.
- ID_Jump=1 with ID_Rs matching load in EX -> stall cycle with IFID_Flush=0, next cycle IFID_Flush=1.
- Rst pulsed in second MULT_BUSY cycle -> next cycle RUN outputs, StallCount=0; StallCount preloaded near max via long busy runs saturates at all-ones.
